// File: rtl/mcbsp_slave_rx.sv
// McBSP slave receiver: oversamples DSP clkx/fsx/dx in the FPGA clock domain and
// assembles MSB-first words with per-frame word addressing and error strobes.
module mcbsp_slave_rx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              mcbsp_clk_in,
  input  logic              mcbsp_rst_n_in,
  input  logic [8:0]        mcbsp_reg_number,
  input  logic              mcbsp_slave_en,
  input  logic              mcbsp_slave_clkx,
  input  logic              mcbsp_slave_fsx,
  input  logic              mcbsp_slave_mosi,
  output logic [DATA_W-1:0] mcbsp_rx_data,
  output logic              mcbsp_rx_valid,
  output logic [8:0]        mcbsp_rx_addr,
  output logic              mcbsp_rx_frame_done,
  output logic              mcbsp_rx_err,
  output logic [63:0]       debug_signal
);

  localparam int unsigned BCW = $clog2(DATA_W);
  localparam int unsigned TCW = $clog2(TIMEOUT);
  localparam int unsigned AW  = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_FS = 2'd1,
    SHIFT   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic              clkx_s1, clkx_s2, clkx_s3;
  logic              fsx_s1, fsx_s2;
  logic              mosi_s1, mosi_s2;
  logic              rise;
  logic [BCW-1:0]    bit_cnt;
  logic [AW-1:0]     word_cnt;
  logic [AW-1:0]     n_reg;
  logic [AW-1:0]     n_req;
  logic [AW-1:0]     n_cur;
  logic [TCW-1:0]    tcnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nx;
  logic              last_bit;
  logic              tmo_hit;
  logic              frame_end;
  logic              word_done;
  logic              fs_err;
  logic              tmo_err;

  // Two-flop synchronisers; third clkx flop for rising-edge detect
  always_ff @(posedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) begin
      clkx_s1 <= 1'b0;
      clkx_s2 <= 1'b0;
      clkx_s3 <= 1'b0;
      fsx_s1  <= 1'b0;
      fsx_s2  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      clkx_s1 <= mcbsp_slave_clkx;
      clkx_s2 <= clkx_s1;
      clkx_s3 <= clkx_s2;
      fsx_s1  <= mcbsp_slave_fsx;
      fsx_s2  <= fsx_s1;
      mosi_s1 <= mcbsp_slave_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign rise      = clkx_s2 & ~clkx_s3;
  assign last_bit  = (bit_cnt == BCW'(DATA_W - 1));
  assign tmo_hit   = (tcnt == TCW'(TIMEOUT - 1));
  assign shreg_nx  = {shreg[DATA_W-2:0], mosi_s2};
  // Frame length is taken live on the first word of a frame, then held
  assign n_req     = (mcbsp_reg_number == '0) ? AW'(1) : mcbsp_reg_number;
  assign n_cur     = (word_cnt == '0) ? n_req : n_reg;
  assign frame_end = (word_cnt == n_cur - AW'(1));

  always_ff @(posedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) state <= IDLE;
    else                 state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!mcbsp_slave_en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = WAIT_FS;
        WAIT_FS: if (rise && fsx_s2) state_nx = SHIFT;
        SHIFT: begin
          if (rise) begin
            if (last_bit && !fsx_s2) state_nx = WAIT_FS;
          end else if (tmo_hit) begin
            state_nx = WAIT_FS;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Per-cycle events decoded from the current state
  always_comb begin
    word_done = 1'b0;
    fs_err    = 1'b0;
    tmo_err   = 1'b0;
    if (mcbsp_slave_en && state == SHIFT) begin
      if (rise) begin
        if (last_bit)                        word_done = 1'b1;
        else if (fsx_s2 && bit_cnt != '0)    fs_err    = 1'b1;
      end else if (tmo_hit) begin
        tmo_err = 1'b1;
      end
    end
  end

  always_ff @(posedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
    if (!mcbsp_rst_n_in) begin
      bit_cnt             <= '0;
      word_cnt            <= '0;
      n_reg               <= AW'(1);
      tcnt                <= '0;
      shreg               <= '0;
      mcbsp_rx_data       <= '0;
      mcbsp_rx_valid      <= 1'b0;
      mcbsp_rx_addr       <= '0;
      mcbsp_rx_frame_done <= 1'b0;
      mcbsp_rx_err        <= 1'b0;
    end else begin
      mcbsp_rx_valid      <= 1'b0;
      mcbsp_rx_frame_done <= 1'b0;
      mcbsp_rx_err        <= 1'b0;
      if (!mcbsp_slave_en) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
        tcnt     <= '0;
        shreg    <= '0;
      end else if (state == WAIT_FS) begin
        tcnt <= '0;
        if (rise && fsx_s2) begin
          bit_cnt <= '0;
          shreg   <= '0;
        end
      end else if (state == SHIFT) begin
        if (rise) begin
          tcnt <= '0;
          if (word_done) begin
            mcbsp_rx_data  <= shreg_nx;
            mcbsp_rx_valid <= 1'b1;
            mcbsp_rx_addr  <= word_cnt;
            shreg          <= '0;
            bit_cnt        <= '0;
            if (word_cnt == '0) n_reg <= n_req;
            if (frame_end) begin
              mcbsp_rx_frame_done <= 1'b1;
              word_cnt            <= '0;
            end else begin
              word_cnt <= word_cnt + AW'(1);
            end
          end else if (fs_err) begin
            mcbsp_rx_err <= 1'b1;
            bit_cnt      <= '0;
            shreg        <= '0;
          end else if (!(fsx_s2 && bit_cnt == '0)) begin
            shreg   <= shreg_nx;
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end else if (tmo_err) begin
          mcbsp_rx_err <= 1'b1;
          tcnt         <= '0;
          bit_cnt      <= '0;
          word_cnt     <= '0;
          shreg        <= '0;
        end else begin
          tcnt <= tcnt + TCW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  always_comb begin
    debug_signal        = '0;
    debug_signal[1:0]   = state;
    debug_signal[7:2]   = 6'(bit_cnt);
    debug_signal[16:8]  = word_cnt;
    debug_signal[19:17] = {clkx_s2, fsx_s2, mosi_s2};
    debug_signal[51:20] = 32'(shreg);
  end

endmodule
